pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter NREG, default 32, number of architectural registers; AW = clog2(NREG) is the register-index width.
REQ-002 Parameter CNT_W, default 32, width of the performance counters.
REQ-003 Parameter FLUSH_CYCLES, default 2, valid range 1..15, number of cycles flush is asserted per taken branch.
REQ-004 Parameter MEM_TIMEOUT, default 255, maximum MEM_WAIT cycles before the error state.
REQ-005 Parameter FWD_EN, default 1; 1 = forwarding mode, 0 = stall-on-RAW mode.
REQ-006 clk  in  1  single clock; all state updates on the rising edge.
REQ-007 reset  in  1  asynchronous, active-high.
REQ-008 ifid_rs1, ifid_rs2  in  AW  source registers of the instruction in ID.
REQ-009 idex_rs1, idex_rs2, idex_rd  in  AW  register fields of the instruction in EX.
REQ-010 idex_memread, idex_regwrite  in  1  EX-stage control bits.
REQ-011 exmem_rd  in  AW; exmem_regwrite  in  1  MEM-stage destination.
REQ-012 memwb_rd  in  AW; memwb_regwrite  in  1  WB-stage destination.
REQ-013 branch_taken  in  1  resolved taken branch in MEM.
REQ-014 dmem_req, dmem_ready  in  1  data-memory access request and completion.
REQ-015 wb_valid  in  1  instruction retiring this cycle.
REQ-016 forward_a, forward_b  out  2  ALU operand select: 00 = regfile, 01 = WB write data, 10 = EX/MEM ALU result.
REQ-017 pc_write, ifid_write, idex_write, exmem_write  out  1  stage-register enables.
REQ-018 idex_bubble, ifid_flush, idex_flush, exmem_flush  out  1  stage-register clear requests.
REQ-019 state  out  2  FSM state; mem_error  out  1  sticky timeout flag.
REQ-020 stall_count, flush_count, retire_count  out  CNT_W  performance counters.

Function
REQ-021 FSM states: RUN=0, FLUSH=1, MEM_WAIT=2, ERROR=3.
REQ-022 Forwarding (FWD_EN=1), combinational: select 10 if exmem_regwrite, exmem_rd!=0 and exmem_rd==idex_rsX; else select 01 if memwb_regwrite, memwb_rd!=0 and memwb_rd==idex_rsX; else 00. When FWD_EN=0, both forward outputs are 00.
REQ-023 Load-use hazard: idex_memread, idex_rd!=0, and idex_rd equals ifid_rs1 or ifid_rs2.
REQ-024 RAW hazard (FWD_EN=0 only): ifid_rs1 or ifid_rs2 equals a nonzero idex_rd with idex_regwrite, or equals a nonzero exmem_rd with exmem_regwrite.
REQ-025 freeze = (state==MEM_WAIT) or (state==RUN and dmem_req and !dmem_ready) or (state==ERROR).
REQ-026 freeze drives pc_write, ifid_write, idex_write and exmem_write to 0; all flush and bubble outputs are 0; branch_taken is ignored.
REQ-027 Flush, when not frozen: asserted if (state==RUN and branch_taken) or state==FLUSH.
REQ-028 Flush drives ifid_flush, idex_flush and exmem_flush to 1 and pc_write to 1 (target load).
REQ-029 Stall (load-use or RAW), when neither frozen nor flushing: pc_write=0, ifid_write=0, idex_bubble=1, idex_write=1. Priority is freeze > flush > stall.
REQ-030 Otherwise all write enables are 1 and all flush/bubble outputs are 0.
REQ-031 RUN transitions:
  - dmem_req && !dmem_ready -> MEM_WAIT, wait counter = 1.
  - Else branch_taken with FLUSH_CYCLES>1 -> FLUSH, flush counter = FLUSH_CYCLES-1.
  - Else stay in RUN.
REQ-032 FLUSH transitions: decrement the flush counter; return to RUN when it reaches 0. A branch_taken during FLUSH is ignored.
REQ-033 MEM_WAIT transitions:
  - dmem_ready -> RUN in the next cycle.
  - Else wait counter == MEM_TIMEOUT -> ERROR and set mem_error.
  - Else increment the wait counter.
REQ-034 ERROR is held, with freeze active, until reset.
REQ-035 stall_count increments in every cycle where pc_write==0.
REQ-036 flush_count increments once per accepted branch_taken (state RUN, not frozen).
REQ-037 retire_count increments when wb_valid==1.
REQ-038 All counters saturate at 2^CNT_W-1 and are not cleared by a state change.

Reset
REQ-039 Reset, asynchronously and at any time including mid-FLUSH or mid-MEM_WAIT, sets state=RUN, mem_error=0, all counters and internal counters to 0.
REQ-040 After reset, combinational outputs follow REQ-022 to REQ-030 using state RUN.

Verification
REQ-041 Load-use: idex_memread=1, idex_rd=5, ifid_rs2=5 -> one cycle with pc_write=0 and idex_bubble=1; stall_count=1.
REQ-042 Forward priority: exmem_rd=memwb_rd=idex_rs1=7, both regwrite=1 -> forward_a=10; exmem_rd=0 -> forward_a=01.
REQ-043 Branch with FLUSH_CYCLES=2: branch_taken pulse in RUN -> flush high for 2 cycles, state 0->1->0, flush_count=1.
REQ-044 Memory wait: dmem_req=1, dmem_ready low for 3 cycles -> all enables 0 for 4 cycles, state=2, then RUN; branch_taken during wait ignored.
REQ-045 Timeout with MEM_TIMEOUT=4: dmem_ready held 0 -> state=3 and mem_error=1 after the wait counter reaches 4; reset -> state=0, counters 0.
REQ-046 FWD_EN=0: idex_regwrite=1, idex_rd=3, ifid_rs1=3 -> stall asserted and forward_a=00.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller for a classic 5-stage in-order pipeline.
// Resolves operand forwarding, load-use / RAW stalls, branch flushes and
// data-memory wait/timeout freezes, and keeps saturating performance counters.
module pipeline_hazard_ctrl #(
  parameter int NREG         = 32,
  parameter int CNT_W        = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 255,
  parameter int FWD_EN       = 1,
  localparam int AW          = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic             clk,
  input  logic             reset,
  // ID-stage sources
  input  logic [AW-1:0]    ifid_rs1,
  input  logic [AW-1:0]    ifid_rs2,
  // EX-stage fields
  input  logic [AW-1:0]    idex_rs1,
  input  logic [AW-1:0]    idex_rs2,
  input  logic [AW-1:0]    idex_rd,
  input  logic             idex_memread,
  input  logic             idex_regwrite,
  // MEM / WB destinations
  input  logic [AW-1:0]    exmem_rd,
  input  logic             exmem_regwrite,
  input  logic [AW-1:0]    memwb_rd,
  input  logic             memwb_regwrite,
  // Control events
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             wb_valid,
  // Forwarding selects
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  // Stage-register enables
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  // Stage-register clears
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  // Status
  output logic [1:0]       state,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] retire_count
);

  // Wide enough to hold MEM_TIMEOUT itself.
  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_ERROR    = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [3:0]        flush_cnt_reg, flush_cnt_next;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic              mem_error_reg, mem_error_next;

  // ---------------------------------------------------------------------
  // Per-operand hazard detection. Index 0 = rs1 / operand A, 1 = rs2 / B.
  // ---------------------------------------------------------------------
  logic [1:0][AW-1:0] ex_src;
  logic [1:0][AW-1:0] id_src;
  logic [1:0]         ex_hit;
  logic [1:0]         wb_hit;
  logic [1:0][1:0]    fwd_sel;
  logic [1:0]         lu_hit;
  logic [1:0]         raw_hit;

  assign ex_src = {idex_rs2, idex_rs1};
  assign id_src = {ifid_rs2, ifid_rs1};

  // Register 0 is hardwired, so a write to it never creates a dependency.
  logic exmem_writes, memwb_writes, idex_writes, idex_loads;
  assign exmem_writes = exmem_regwrite && (exmem_rd != '0);
  assign memwb_writes = memwb_regwrite && (memwb_rd != '0);
  assign idex_writes  = idex_regwrite  && (idex_rd  != '0);
  assign idex_loads   = idex_memread   && (idex_rd  != '0);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      // EX/MEM is younger than MEM/WB, so it wins when both match.
      assign ex_hit[gi]  = exmem_writes && (exmem_rd == ex_src[gi]);
      assign wb_hit[gi]  = memwb_writes && (memwb_rd == ex_src[gi]);
      assign fwd_sel[gi] = (FWD_EN == 0) ? 2'b00 :
                           ex_hit[gi]    ? 2'b10 :
                           wb_hit[gi]    ? 2'b01 : 2'b00;

      // Load result is not available in time even with forwarding.
      assign lu_hit[gi]  = idex_loads && (idex_rd == id_src[gi]);

      // Without forwarding, any in-flight producer in EX or MEM blocks ID.
      assign raw_hit[gi] = (idex_writes  && (idex_rd  == id_src[gi])) ||
                           (exmem_writes && (exmem_rd == id_src[gi]));
    end
  endgenerate

  assign forward_a = fwd_sel[0];
  assign forward_b = fwd_sel[1];

  logic load_use;
  logic raw_hazard;
  assign load_use   = |lu_hit;
  assign raw_hazard = (FWD_EN == 0) && (|raw_hit);

  // ---------------------------------------------------------------------
  // Pipeline control: freeze > flush > stall > normal flow.
  // ---------------------------------------------------------------------
  logic freeze;
  logic flush_active;
  logic stall;
  logic branch_accept;
  logic mem_miss;

  assign mem_miss = dmem_req && !dmem_ready;

  // Decode the priority of pipeline actions for this cycle.
  always_comb begin
    freeze        = 1'b0;
    flush_active  = 1'b0;
    stall         = 1'b0;
    branch_accept = 1'b0;

    unique case (state_reg)
      ST_RUN:      freeze = mem_miss;
      ST_FLUSH:    freeze = 1'b0;
      ST_MEM_WAIT: freeze = 1'b1;
      ST_ERROR:    freeze = 1'b1;
      default:     freeze = 1'b1;
    endcase

    if (!freeze) begin
      branch_accept = (state_reg == ST_RUN) && branch_taken;
      flush_active  = branch_accept || (state_reg == ST_FLUSH);
      stall         = !flush_active && (load_use || raw_hazard);
    end
  end

  // Drive the stage-register enables and clear requests.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    exmem_write = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;

    if (freeze) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
    end else if (flush_active) begin
      // PC keeps loading so the branch target is fetched.
      pc_write    = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (stall) begin
      // Hold PC and IF/ID, inject a bubble into EX.
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      idex_write  = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Controller FSM
  // ---------------------------------------------------------------------

  // Next-state, flush/wait counters and sticky error.
  always_comb begin
    state_next     = state_reg;
    flush_cnt_next = flush_cnt_reg;
    wait_cnt_next  = wait_cnt_reg;
    mem_error_next = mem_error_reg;

    unique case (state_reg)
      ST_RUN: begin
        if (mem_miss) begin
          // Memory stall has priority; a simultaneous branch is dropped.
          state_next    = ST_MEM_WAIT;
          wait_cnt_next = WAIT_W'(1);
        end else if (branch_taken && (FLUSH_CYCLES > 1)) begin
          // This cycle already flushes, so FLUSH covers the remainder.
          state_next     = ST_FLUSH;
          flush_cnt_next = 4'(FLUSH_CYCLES - 1);
        end
      end

      ST_FLUSH: begin
        // Branches arriving here are wrong-path and ignored.
        if (flush_cnt_reg <= 4'd1) begin
          state_next     = ST_RUN;
          flush_cnt_next = 4'd0;
        end else begin
          flush_cnt_next = flush_cnt_reg - 4'd1;
        end
      end

      ST_MEM_WAIT: begin
        if (dmem_ready) begin
          state_next    = ST_RUN;
          wait_cnt_next = '0;
        end else if (wait_cnt_reg == WAIT_W'(MEM_TIMEOUT)) begin
          state_next     = ST_ERROR;
          mem_error_next = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
        end
      end

      ST_ERROR: begin
        // Terminal until reset.
        state_next = ST_ERROR;
      end

      default: begin
        state_next = ST_ERROR;
      end
    endcase
  end

  // FSM state and internal counters register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_RUN;
      flush_cnt_reg <= 4'd0;
      wait_cnt_reg  <= '0;
      mem_error_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      flush_cnt_reg <= flush_cnt_next;
      wait_cnt_reg  <= wait_cnt_next;
      mem_error_reg <= mem_error_next;
    end
  end

  assign state     = state_reg;
  assign mem_error = mem_error_reg;

  // ---------------------------------------------------------------------
  // Saturating performance counters: 0 = stall, 1 = flush, 2 = retire.
  // ---------------------------------------------------------------------
  logic [2:0]            cnt_inc;
  logic [2:0][CNT_W-1:0] cnt_bus;

  assign cnt_inc[0] = !pc_write;
  assign cnt_inc[1] = branch_accept;
  assign cnt_inc[2] = wb_valid;

  generate
    for (gi = 0; gi < 3; gi++) begin : g_perf
      logic [CNT_W-1:0] count_reg;

      // Count events, sticking at all-ones instead of wrapping.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          count_reg <= '0;
        end else if (cnt_inc[gi] && (count_reg != {CNT_W{1'b1}})) begin
          count_reg <= count_reg + CNT_W'(1);
        end
      end

      assign cnt_bus[gi] = count_reg;
    end
  endgenerate

  assign stall_count  = cnt_bus[0];
  assign flush_count  = cnt_bus[1];
  assign retire_count = cnt_bus[2];

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl. Two instances share the same
// stimulus: index 0 forwards (FLUSH_CYCLES=2, MEM_TIMEOUT=4, 32-bit counters),
// index 1 stalls on RAW (FLUSH_CYCLES=3, MEM_TIMEOUT=6, 6-bit counters).
module tb_pipeline_hazard_ctrl;

  localparam int NI = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [4:0] ifid_rs1, ifid_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd;
  logic idex_memread, idex_regwrite, exmem_regwrite, memwb_regwrite;
  logic branch_taken, dmem_req, dmem_ready, wb_valid;

  logic [1:0] a_fa[NI], a_fb[NI], a_st[NI];
  logic a_pcw[NI], a_ifw[NI], a_idw[NI], a_exw[NI];
  logic a_bub[NI], a_iff[NI], a_idf[NI], a_exf[NI], a_err[NI];
  logic [31:0] f_stall, f_flush, f_retire;
  logic [5:0]  s_stall, s_flush, s_retire;

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(4), .FWD_EN(1)) u_fwd (
    .clk(clk), .reset(reset),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd),
    .idex_memread(idex_memread), .idex_regwrite(idex_regwrite),
    .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
    .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite),
    .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .wb_valid(wb_valid),
    .forward_a(a_fa[0]), .forward_b(a_fb[0]),
    .pc_write(a_pcw[0]), .ifid_write(a_ifw[0]), .idex_write(a_idw[0]), .exmem_write(a_exw[0]),
    .idex_bubble(a_bub[0]), .ifid_flush(a_iff[0]), .idex_flush(a_idf[0]), .exmem_flush(a_exf[0]),
    .state(a_st[0]), .mem_error(a_err[0]),
    .stall_count(f_stall), .flush_count(f_flush), .retire_count(f_retire)
  );

  pipeline_hazard_ctrl #(.CNT_W(6), .FLUSH_CYCLES(3), .MEM_TIMEOUT(6), .FWD_EN(0)) u_stl (
    .clk(clk), .reset(reset),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd),
    .idex_memread(idex_memread), .idex_regwrite(idex_regwrite),
    .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
    .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite),
    .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .wb_valid(wb_valid),
    .forward_a(a_fa[1]), .forward_b(a_fb[1]),
    .pc_write(a_pcw[1]), .ifid_write(a_ifw[1]), .idex_write(a_idw[1]), .exmem_write(a_exw[1]),
    .idex_bubble(a_bub[1]), .ifid_flush(a_iff[1]), .idex_flush(a_idf[1]), .exmem_flush(a_exf[1]),
    .state(a_st[1]), .mem_error(a_err[1]),
    .stall_count(s_stall), .flush_count(s_flush), .retire_count(s_retire)
  );

  // Per-instance configuration seen by the model.
  int     p_fwd[NI] = '{1, 0};
  int     p_fc[NI]  = '{2, 3};
  int     p_to[NI]  = '{4, 6};
  longint p_max[NI] = '{64'd4294967295, 64'd63};

  // Model state: remaining FLUSH-state cycles, wait bookkeeping, error, counters.
  int     m_flush_left[NI];
  bit     m_waiting[NI];
  int     m_waited[NI];
  bit     m_err[NI];
  longint m_stall[NI], m_fl[NI], m_ret[NI];

  // Expected outputs for the current cycle.
  logic [1:0] e_fa[NI], e_fb[NI], e_st[NI];
  logic e_pcw[NI], e_ifw[NI], e_idw[NI], e_exw[NI], e_bub[NI], e_fl[NI];
  bit   e_acc[NI];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int m_state(input int k);
    if (m_err[k]) return 3;
    if (m_waiting[k]) return 2;
    if (m_flush_left[k] > 0) return 1;
    return 0;
  endfunction

  function automatic logic [1:0] fsel(input int k, input logic [4:0] rs);
    if (p_fwd[k] == 0) return 2'd0;
    if (exmem_regwrite && exmem_rd != 0 && exmem_rd == rs) return 2'd2;
    if (memwb_regwrite && memwb_rd != 0 && memwb_rd == rs) return 2'd1;
    return 2'd0;
  endfunction

  function automatic bit reads(input logic [4:0] rd);
    return rd != 0 && (rd == ifid_rs1 || rd == ifid_rs2);
  endfunction

  task automatic compute(input int k);
    int st;
    bit frz, fl, lu, raw, stl;
    st  = m_state(k);
    frz = (st >= 2) || (st == 0 && dmem_req && !dmem_ready);
    fl  = !frz && ((st == 0 && branch_taken) || st == 1);
    lu  = idex_memread && reads(idex_rd);
    raw = (p_fwd[k] == 0) && ((idex_regwrite && reads(idex_rd)) || (exmem_regwrite && reads(exmem_rd)));
    stl = !frz && !fl && (lu || raw);
    e_fa[k]  = fsel(k, idex_rs1);
    e_fb[k]  = fsel(k, idex_rs2);
    e_pcw[k] = !frz && !stl;
    e_ifw[k] = !frz && !stl;
    e_idw[k] = !frz;
    e_exw[k] = !frz;
    e_bub[k] = stl;
    e_fl[k]  = fl;
    e_st[k]  = 2'(st);
    e_acc[k] = (st == 0) && !frz && branch_taken;
  endtask

  function automatic logic [63:0] cnt_act(input int k, input int which);
    if (k == 0) return (which == 0) ? 64'(f_stall) : (which == 1) ? 64'(f_flush) : 64'(f_retire);
    return (which == 0) ? 64'(s_stall) : (which == 1) ? 64'(s_flush) : 64'(s_retire);
  endfunction

  task automatic check_outputs();
    for (int k = 0; k < NI; k++) begin
      compute(k);
      chk($sformatf("u%0d.forward_a", k),   64'(a_fa[k]),  64'(e_fa[k]));
      chk($sformatf("u%0d.forward_b", k),   64'(a_fb[k]),  64'(e_fb[k]));
      chk($sformatf("u%0d.pc_write", k),    64'(a_pcw[k]), 64'(e_pcw[k]));
      chk($sformatf("u%0d.ifid_write", k),  64'(a_ifw[k]), 64'(e_ifw[k]));
      chk($sformatf("u%0d.idex_write", k),  64'(a_idw[k]), 64'(e_idw[k]));
      chk($sformatf("u%0d.exmem_write", k), 64'(a_exw[k]), 64'(e_exw[k]));
      chk($sformatf("u%0d.idex_bubble", k), 64'(a_bub[k]), 64'(e_bub[k]));
      chk($sformatf("u%0d.ifid_flush", k),  64'(a_iff[k]), 64'(e_fl[k]));
      chk($sformatf("u%0d.idex_flush", k),  64'(a_idf[k]), 64'(e_fl[k]));
      chk($sformatf("u%0d.exmem_flush", k), 64'(a_exf[k]), 64'(e_fl[k]));
      chk($sformatf("u%0d.state", k),       64'(a_st[k]),  64'(e_st[k]));
      chk($sformatf("u%0d.mem_error", k),   64'(a_err[k]), 64'(m_err[k]));
      chk($sformatf("u%0d.stall_count", k),  cnt_act(k, 0), 64'(m_stall[k]));
      chk($sformatf("u%0d.flush_count", k),  cnt_act(k, 1), 64'(m_fl[k]));
      chk($sformatf("u%0d.retire_count", k), cnt_act(k, 2), 64'(m_ret[k]));
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_flush_left[k] = 0; m_waiting[k] = 0; m_waited[k] = 0; m_err[k] = 0;
      m_stall[k] = 0; m_fl[k] = 0; m_ret[k] = 0;
    end
  endtask

  task automatic model_update();
    int st;
    for (int k = 0; k < NI; k++) begin
      compute(k);
      st = m_state(k);
      if (!e_pcw[k] && m_stall[k] < p_max[k]) m_stall[k]++;
      if (e_acc[k] && m_fl[k] < p_max[k]) m_fl[k]++;
      if (wb_valid && m_ret[k] < p_max[k]) m_ret[k]++;
      case (st)
        0: begin
          if (dmem_req && !dmem_ready) begin m_waiting[k] = 1; m_waited[k] = 1; end
          else if (branch_taken) m_flush_left[k] = p_fc[k] - 1;
        end
        1: m_flush_left[k]--;
        2: begin
          if (dmem_ready) m_waiting[k] = 0;
          else if (m_waited[k] == p_to[k]) begin m_err[k] = 1; m_waiting[k] = 0; end
          else m_waited[k]++;
        end
        default: ;
      endcase
    end
  endtask

  task automatic tick_check();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic tick_commit();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic step();
    tick_check();
    tick_commit();
  endtask

  // Pulse reset in the low clock phase and confirm it acts without a clock edge.
  task automatic async_reset();
    #1 reset = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("u%0d.rst_state", k),  64'(a_st[k]), 64'd0);
      chk($sformatf("u%0d.rst_err", k),    64'(a_err[k]), 64'd0);
      chk($sformatf("u%0d.rst_stall", k),  cnt_act(k, 0), 64'd0);
      chk($sformatf("u%0d.rst_flush", k),  cnt_act(k, 1), 64'd0);
      chk($sformatf("u%0d.rst_retire", k), cnt_act(k, 2), 64'd0);
    end
    model_reset();
    #1 reset = 1'b0;
  endtask

  task automatic clear_inputs();
    ifid_rs1 = 0; ifid_rs2 = 0; idex_rs1 = 0; idex_rs2 = 0; idex_rd = 0;
    exmem_rd = 0; memwb_rd = 0;
    idex_memread = 0; idex_regwrite = 0; exmem_regwrite = 0; memwb_regwrite = 0;
    branch_taken = 0; dmem_req = 0; dmem_ready = 0; wb_valid = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    reset = 1'b1;
    model_reset();
    #2 reset = 1'b0;
    tick_commit();

    // Reset state
    tick_check();
    chk("init_state", 64'(a_st[0]), 64'd0);
    chk("init_pcw",   64'(a_pcw[0]), 64'd1);
    chk("init_stall", 64'(f_stall), 64'd0);
    tick_commit();

    // Load-use: exactly one stall cycle
    idex_memread = 1; idex_regwrite = 1; idex_rd = 5; ifid_rs2 = 5;
    tick_check();
    chk("lu_pcw",  64'(a_pcw[0]), 64'd0);
    chk("lu_bub",  64'(a_bub[0]), 64'd1);
    chk("lu_ifw",  64'(a_ifw[0]), 64'd0);
    chk("lu_idw",  64'(a_idw[0]), 64'd1);
    tick_commit();
    clear_inputs();
    tick_check();
    chk("lu_stall_count", 64'(f_stall), 64'd1);
    chk("lu_after_pcw", 64'(a_pcw[0]), 64'd1);
    tick_commit();

    // Forward priority
    exmem_rd = 7; memwb_rd = 7; idex_rs1 = 7; exmem_regwrite = 1; memwb_regwrite = 1;
    tick_check();
    chk("fwd_exmem", 64'(a_fa[0]), 64'd2);
    chk("fwd_off",   64'(a_fa[1]), 64'd0);
    tick_commit();
    exmem_rd = 0;
    tick_check();
    chk("fwd_memwb", 64'(a_fa[0]), 64'd1);
    tick_commit();
    clear_inputs();

    // Branch flush, two cycles
    branch_taken = 1;
    tick_check();
    chk("br_flush0", 64'(a_iff[0]), 64'd1);
    chk("br_state0", 64'(a_st[0]), 64'd0);
    chk("br_pcw0",   64'(a_pcw[0]), 64'd1);
    tick_commit();
    branch_taken = 0;
    tick_check();
    chk("br_state1", 64'(a_st[0]), 64'd1);
    chk("br_flush1", 64'(a_exf[0]), 64'd1);
    chk("br_count",  64'(f_flush), 64'd1);
    tick_commit();
    tick_check();
    chk("br_state2", 64'(a_st[0]), 64'd0);
    chk("br_flush2", 64'(a_iff[0]), 64'd0);
    tick_commit();

    // Memory wait, branch ignored during it
    dmem_req = 1; branch_taken = 1;
    for (int i = 0; i < 4; i++) begin
      dmem_ready = (i == 3);
      tick_check();
      chk($sformatf("mw_pcw%0d", i), 64'(a_pcw[0]), 64'd0);
      chk($sformatf("mw_exw%0d", i), 64'(a_exw[0]), 64'd0);
      chk($sformatf("mw_state%0d", i), 64'(a_st[0]), (i == 0) ? 64'd0 : 64'd2);
      tick_commit();
    end
    clear_inputs();
    tick_check();
    chk("mw_done_state", 64'(a_st[0]), 64'd0);
    chk("mw_done_pcw",   64'(a_pcw[0]), 64'd1);
    chk("mw_stall_count", 64'(f_stall), 64'd5);
    chk("mw_flush_count", 64'(f_flush), 64'd1);
    tick_commit();

    // RAW stall without forwarding
    idex_regwrite = 1; idex_rd = 3; ifid_rs1 = 3; idex_rs1 = 3; exmem_rd = 3; exmem_regwrite = 1;
    tick_check();
    chk("raw_pcw", 64'(a_pcw[1]), 64'd0);
    chk("raw_bub", 64'(a_bub[1]), 64'd1);
    chk("raw_fa",  64'(a_fa[1]), 64'd0);
    chk("raw_fwd_pcw", 64'(a_pcw[0]), 64'd1);
    chk("raw_fwd_fa",  64'(a_fa[0]), 64'd2);
    tick_commit();
    clear_inputs();

    // Timeout into ERROR, then counter saturation while held
    dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 6; i++) begin
      tick_check();
      if (i == 4) begin
        chk("to_state_at_limit", 64'(a_st[0]), 64'd2);
        chk("to_err_at_limit",   64'(a_err[0]), 64'd0);
      end
      if (i == 5) begin
        chk("to_state_err", 64'(a_st[0]), 64'd3);
        chk("to_err_flag",  64'(a_err[0]), 64'd1);
      end
      tick_commit();
    end
    dmem_req = 0;
    for (int i = 0; i < 80; i++) step();
    tick_check();
    chk("to_held_state", 64'(a_st[0]), 64'd3);
    chk("to_stall_91",   64'(f_stall), 64'd91);
    chk("sat_stall_63",  64'(s_stall), 64'd63);
    chk("sat_state",     64'(a_st[1]), 64'd3);
    async_reset();
    tick_commit();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      ifid_rs1 = 5'($urandom_range(0, 7)); ifid_rs2 = 5'($urandom_range(0, 7));
      idex_rs1 = 5'($urandom_range(0, 7)); idex_rs2 = 5'($urandom_range(0, 7));
      idex_rd  = 5'($urandom_range(0, 7)); exmem_rd = 5'($urandom_range(0, 7));
      memwb_rd = 5'($urandom_range(0, 7));
      idex_memread   = ($urandom_range(0, 9) < 3);
      idex_regwrite  = $urandom_range(0, 1);
      exmem_regwrite = $urandom_range(0, 1);
      memwb_regwrite = $urandom_range(0, 1);
      branch_taken   = ($urandom_range(0, 9) == 0);
      dmem_req       = ($urandom_range(0, 9) < 2);
      dmem_ready     = $urandom_range(0, 1);
      wb_valid       = $urandom_range(0, 1);
      tick_check();
      if ($urandom_range(0, 99) == 0) async_reset();
      tick_commit();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
